axi_lite_mem_slave: RTL

- AXI4-Lite responder (slave) that terminates the AR/R/AW/W/B channels driven by the team's invalid/outvalid-to-AXI4-Lite bridge.
- Backed by a word-addressed register-file memory with programmable read and write response latency.
- Serves as the DRAM-side endpoint in simulation and formal benches.
- Read and write paths run as independent state machines sharing one memory array.

---
 rtl/axi_lite_mem_slave.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a word-addressed register file. Read and write
// paths are independent FSMs with programmable response latency.
module axi_lite_mem_slave #(
  parameter int         DATA_W = 32,
  parameter int         IDX_W  = 7,
  parameter int         ADDR_W = 17,
  parameter logic [7:0] BASE   = 8'h80,
  parameter int         RD_LAT = 2,
  parameter int         WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY
);

  localparam int         DEPTH       = 2 ** IDX_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] RD_CNT_INIT = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [3:0] WR_CNT_INIT = 4'((WR_LAT > 0) ? WR_LAT - 1 : 0);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rdState_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wrState_t;

  rdState_t          r_rdState;
  logic [3:0]        r_rdCnt;
  logic [IDX_W-1:0]  r_arIdx;
  logic              r_arOk;

  wrState_t          r_wrState;
  logic [3:0]        r_wrCnt;
  logic [IDX_W-1:0]  r_awIdx;
  logic              r_awOk;
  logic [DATA_W-1:0] r_wData;
  logic              r_awHeld;
  logic              r_wHeld;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_arHs;
  logic w_awHs;
  logic w_wHs;
  logic w_unusedAddrBits;

  assign w_arHs = AR_VALID & AR_READY;
  assign w_awHs = AW_VALID & AW_READY;
  assign w_wHs  = W_VALID & W_READY;

  // Byte-lane bits never select anything in a word-addressed memory.
  assign w_unusedAddrBits = ^{AR_ADDR[1:0], AW_ADDR[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdState <= RD_IDLE;
      r_rdCnt   <= '0;
      r_arIdx   <= '0;
      r_arOk    <= 1'b0;
      AR_READY  <= 1'b1;
      R_VALID   <= 1'b0;
      R_DATA    <= '0;
      R_RESP    <= RESP_OKAY;
    end else begin
      case (r_rdState)
        RD_IDLE: begin
          if (w_arHs) begin
            r_arIdx  <= AR_ADDR[IDX_W+1:2];
            r_arOk   <= (AR_ADDR[ADDR_W-1 -: 8] == BASE);
            AR_READY <= 1'b0;
            if (RD_LAT > 0) begin
              r_rdState <= RD_WAIT;
              r_rdCnt   <= RD_CNT_INIT;
            end else begin
              r_rdState <= RD_DATA;
            end
          end
        end
        RD_WAIT: begin
          if (r_rdCnt == 4'd0) r_rdState <= RD_DATA;
          else                 r_rdCnt   <= r_rdCnt - 4'd1;
        end
        RD_DATA: begin
          // First cycle in RD_DATA loads the payload; it then holds until accepted.
          if (!R_VALID) begin
            R_VALID <= 1'b1;
            R_DATA  <= r_arOk ? r_mem[r_arIdx] : '0;
            R_RESP  <= r_arOk ? RESP_OKAY : RESP_SLVERR;
          end else if (R_READY) begin
            R_VALID   <= 1'b0;
            AR_READY  <= 1'b1;
            r_rdState <= RD_IDLE;
          end
        end
        default: r_rdState <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrState <= WR_IDLE;
      r_wrCnt   <= '0;
      r_awIdx   <= '0;
      r_awOk    <= 1'b0;
      r_wData   <= '0;
      r_awHeld  <= 1'b0;
      r_wHeld   <= 1'b0;
      AW_READY  <= 1'b1;
      W_READY   <= 1'b1;
      B_VALID   <= 1'b0;
      B_RESP    <= RESP_OKAY;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_wrState)
        WR_IDLE: begin
          if (w_awHs) begin
            r_awIdx  <= AW_ADDR[IDX_W+1:2];
            r_awOk   <= (AW_ADDR[ADDR_W-1 -: 8] == BASE);
            r_awHeld <= 1'b1;
            AW_READY <= 1'b0;
          end
          if (w_wHs) begin
            r_wData <= W_DATA;
            r_wHeld <= 1'b1;
            W_READY <= 1'b0;
          end
          if ((r_awHeld || w_awHs) && (r_wHeld || w_wHs)) begin
            if (WR_LAT > 0) begin
              r_wrState <= WR_WAIT;
              r_wrCnt   <= WR_CNT_INIT;
            end else begin
              r_wrState <= WR_RESP;
            end
          end
        end
        WR_WAIT: begin
          if (r_wrCnt == 4'd0) r_wrState <= WR_RESP;
          else                 r_wrCnt   <= r_wrCnt - 4'd1;
        end
        WR_RESP: begin
          if (!B_VALID) begin
            if (r_awOk) r_mem[r_awIdx] <= r_wData;
            B_VALID <= 1'b1;
            B_RESP  <= r_awOk ? RESP_OKAY : RESP_SLVERR;
          end else if (B_READY) begin
            B_VALID   <= 1'b0;
            AW_READY  <= 1'b1;
            W_READY   <= 1'b1;
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_wrState <= WR_IDLE;
          end
        end
        default: r_wrState <= WR_IDLE;
      endcase
    end
  end

endmodule
